nand3_pattern_gen: RTL and testbench

On-chip stimulus and checker stage that sits directly upstream of the loaded three-input NAND cell. It drives the cell's A/B/C inputs through the fixed walking-ones/walking-zeros sequence, then samples Y and both loaded outputs (Yld0, Yld1) after a programmable settle time and counts mismatches. A single Start pulse runs the whole sequence; Done and Pass report the result.

---
 rtl/nand3_pattern_gen.sv | 179 +++++++++++++++++
 tb/tb_nand3_pattern_gen.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/nand3_pattern_gen.sv
// nand3_pattern_gen: stimulus and checker for a loaded three-input NAND cell.
// Walks A/B/C through a fixed seven-step pattern, holds each step for DWELL
// cycles, and at cycle SETTLE of each step compares the synchronised cell
// outputs (Y, Yld0, Yld1) against ~(A & B & C), accumulating a saturating
// mismatch count.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | after reset; drive 000, wait for Start
// ST_RUN   | stepping through the pattern table, checking once per step
// ST_DONE  | run complete; Done/Pass valid, drive 000, Start restarts
module nand3_pattern_gen #(
  parameter int unsigned DWELL  = 100,
  parameter int unsigned SETTLE = 4
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic       Start,
  input  logic       Y,
  input  logic       Yld0,
  input  logic       Yld1,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic [2:0] StepIdx,
  output logic       Busy,
  output logic       Done,
  output logic       Pass,
  output logic [7:0] ErrCount
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);
  localparam logic [15:0] SETTLE_CNT = 16'(SETTLE);
  localparam logic [2:0]  LAST_STEP  = 3'd6;

  // Drive pattern {A,B,C} for each step: walking ones in, then walking zeros.
  function automatic logic [2:0] step_pattern(input logic [2:0] step);
    logic [2:0] abc;
    abc = 3'b000;
    case (step)
      3'd0:    abc = 3'b000;
      3'd1:    abc = 3'b100;
      3'd2:    abc = 3'b110;
      3'd3:    abc = 3'b111;
      3'd4:    abc = 3'b011;
      3'd5:    abc = 3'b001;
      default: abc = 3'b000;
    endcase
    return abc;
  endfunction

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  step_q, step_d;
  logic [2:0]  abc_q, abc_d;
  logic [7:0]  err_q, err_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;

  logic [2:0]  meta_q;
  logic [2:0]  sync_q;

  logic        expected;
  logic [2:0]  mismatch;
  logic [1:0]  miss_cnt;
  logic [8:0]  err_sum;

  // Two-flop synchronisers for the asynchronous cell outputs {Y, Yld0, Yld1}.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      meta_q <= 3'b000;
      sync_q <= 3'b000;
    end else begin
      meta_q <= {Y, Yld0, Yld1};
      sync_q <= meta_q;
    end
  end

  // Mismatch count for the current step; the cell is ideal when all three
  // outputs equal the NAND of the pattern currently being driven.
  always_comb begin
    expected = ~&abc_q;
    mismatch = sync_q ^ {3{expected}};
    miss_cnt = 2'(mismatch[0]) + 2'(mismatch[1]) + 2'(mismatch[2]);
    err_sum  = {1'b0, err_q} + {7'd0, miss_cnt};
  end

  // Sequencer state, dwell counter, drive pattern and result registers.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 16'd0;
      step_q  <= 3'd0;
      abc_q   <= 3'b000;
      err_q   <= 8'd0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      abc_q   <= abc_d;
      err_q   <= err_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state logic: start/restart, per-step check, step advance, finish.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    abc_d   = abc_q;
    err_d   = err_q;
    done_d  = done_q;
    pass_d  = pass_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          state_d = ST_RUN;
          cnt_d   = 16'd0;
          step_d  = 3'd0;
          abc_d   = step_pattern(3'd0);
          err_d   = 8'd0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end

      ST_RUN: begin
        // Start is deliberately ignored here: a run is never restarted.
        if (cnt_q == SETTLE_CNT) begin
          err_d = err_sum[8] ? 8'hFF : err_sum[7:0];
        end
        if (cnt_q == DWELL_LAST) begin
          cnt_d = 16'd0;
          if (step_q == LAST_STEP) begin
            state_d = ST_DONE;
            abc_d   = 3'b000;
            done_d  = 1'b1;
            // err_d rather than err_q so a check on the final cycle counts.
            pass_d  = (err_d == 8'd0);
          end else begin
            step_d = 3'(step_q + 3'd1);
            abc_d  = step_pattern(3'(step_q + 3'd1));
          end
        end else begin
          cnt_d = 16'(cnt_q + 16'd1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = 16'd0;
        step_d  = 3'd0;
        abc_d   = 3'b000;
        err_d   = 8'd0;
        done_d  = 1'b0;
        pass_d  = 1'b0;
      end
    endcase
  end

  assign {A, B, C} = abc_q;
  assign StepIdx   = step_q;
  assign Busy      = (state_q == ST_RUN);
  assign Done      = done_q;
  assign Pass      = pass_q;
  assign ErrCount  = err_q;

endmodule

// File: tb/tb_nand3_pattern_gen.sv
// Bench for nand3_pattern_gen: behavioural cell model with selectable faults
// and output delay; expected per-step patterns and final error counts are
// queued at Start and popped at each step boundary and at Done.
module tb_nand3_pattern_gen;
  localparam int DW = 100;
  localparam int ST = 4;

  logic       Clock;
  logic       nReset;
  logic       Start;
  logic       Y, Yld0, Yld1;
  logic       A, B, C;
  logic [2:0] StepIdx;
  logic       Busy, Done, Pass;
  logic [7:0] ErrCount;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // 0: ideal, 1: Yld1 stuck at 1, 2: all outputs stuck at 0
  int fault_mode = 0;
  int dly        = 0;

  logic [2:0]  pat [7] = '{3'b000, 3'b100, 3'b110, 3'b111, 3'b011, 3'b001, 3'b000};
  logic [15:0] sr = '1;
  logic        nand_now, cell_y;

  int         err_q[$];
  logic [2:0] pat_q[$];

  nand3_pattern_gen #(.DWELL(DW), .SETTLE(ST)) dut (
    .Clock(Clock), .nReset(nReset), .Start(Start),
    .Y(Y), .Yld0(Yld0), .Yld1(Yld1),
    .A(A), .B(B), .C(C), .StepIdx(StepIdx),
    .Busy(Busy), .Done(Done), .Pass(Pass), .ErrCount(ErrCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Cell model: nand3 with an optional whole-cycle output delay.
  assign nand_now = ~(A & B & C);
  always @(posedge Clock) sr <= {sr[14:0], nand_now};
  assign cell_y = (dly == 0) ? nand_now : sr[4'(dly - 1)];
  assign Y    = (fault_mode == 2) ? 1'b0 : cell_y;
  assign Yld0 = (fault_mode == 2) ? 1'b0 : cell_y;
  assign Yld1 = (fault_mode == 1) ? 1'b1 : (fault_mode == 2) ? 1'b0 : cell_y;

  // Expected mismatches over steps 0..last. A change at a step edge reaches
  // the synchronised inputs dly+2 cycles later; if that is past SETTLE the
  // check still sees the previous step's cell output.
  function automatic int exp_err(input int mode, input int d, input int last);
    int  e;
    logic ex, v, y0, y1, y2;
    e = 0;
    for (int n = 0; n <= last; n++) begin
      ex = ~&pat[n];
      if (d + 2 <= ST) v = ex;
      else             v = (n == 0) ? 1'b1 : ~&pat[n-1];
      y0 = (mode == 2) ? 1'b0 : v;
      y1 = (mode == 2) ? 1'b0 : v;
      y2 = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : v;
      e += int'(y0 != ex) + int'(y1 != ex) + int'(y2 != ex);
    end
    return (e > 255) ? 255 : e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic advance_to(input int target);
    repeat (target - cyc) @(posedge Clock);
    #1;
    cyc = target;
  endtask

  task automatic do_start(input int mode, input int d);
    fault_mode = mode;
    dly        = d;
    repeat (20) @(posedge Clock);
    err_q.push_back(exp_err(mode, d, 6));
    for (int n = 0; n < 7; n++) pat_q.push_back(pat[n]);
    @(negedge Clock) Start = 1'b1;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    cyc = 0;
    chk("busy_at_start", 32'(Busy), 1);
    chk("step_at_start", 32'(StepIdx), 0);
    chk("err_cleared", 32'(ErrCount), 0);
    chk("done_cleared", 32'(Done), 0);
    chk("pass_cleared", 32'(Pass), 0);
    chk("abc_step0", 32'({A, B, C}), 32'(pat_q.pop_front()));
  endtask

  task automatic do_run(input int mode, input int d, input bit restart_mid);
    int e;
    do_start(mode, d);
    for (int n = 1; n < 7; n++) begin
      if (restart_mid && n == 3) begin
        advance_to(250);
        Start = 1'b1;
        advance_to(251);
        Start = 1'b0;
        chk("ignored_start_busy", 32'(Busy), 1);
        chk("ignored_start_step", 32'(StepIdx), 2);
      end
      if (n == 4) begin
        advance_to(3 * DW + ST);
        chk("err_before_step3_update", 32'(ErrCount), 32'(exp_err(mode, d, 2)));
        advance_to(3 * DW + ST + 1);
        chk("err_after_step3_update", 32'(ErrCount), 32'(exp_err(mode, d, 3)));
      end
      advance_to(n * DW - 1);
      chk("step_held", 32'(StepIdx), 32'(n - 1));
      advance_to(n * DW);
      chk("step_advance", 32'(StepIdx), 32'(n));
      chk("abc_step", 32'({A, B, C}), 32'(pat_q.pop_front()));
    end
    advance_to(7 * DW - 1);
    chk("busy_before_end", 32'(Busy), 1);
    chk("done_before_end", 32'(Done), 0);
    advance_to(7 * DW);
    e = err_q.pop_front();
    chk("done_at_end", 32'(Done), 1);
    chk("busy_at_end", 32'(Busy), 0);
    chk("errcount_final", 32'(ErrCount), 32'(e));
    chk("pass_final", 32'(Pass), 32'(e == 0));
    chk("abc_idle_done", 32'({A, B, C}), 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_abc"}, 32'({A, B, C}), 0);
    chk({tag, "_step"}, 32'(StepIdx), 0);
    chk({tag, "_busy"}, 32'(Busy), 0);
    chk({tag, "_done"}, 32'(Done), 0);
    chk({tag, "_pass"}, 32'(Pass), 0);
    chk({tag, "_err"}, 32'(ErrCount), 0);
  endtask

  initial begin
    nReset = 1'b0;
    Start  = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    chk_reset_vals("por");
    @(negedge Clock) nReset = 1'b1;

    do_run(0, 0, 1'b0);   // ideal cell
    do_run(1, 0, 1'b0);   // Yld1 stuck at 1
    do_run(2, 0, 1'b0);   // all outputs stuck at 0
    do_run(0, 0, 1'b1);   // restart from DONE, extra Start at cycle 250
    do_run(0, 6, 1'b0);   // slow cell, checked too early
    do_run(0, 1, 1'b0);   // slow cell within the settle window

    // Mid-run reset during step 3, after that step's error was counted.
    do_start(1, 0);
    advance_to(350);
    chk("pre_reset_step", 32'(StepIdx), 3);
    chk("pre_reset_abc", 32'({A, B, C}), 32'b111);
    chk("pre_reset_err", 32'(ErrCount), 1);
    err_q.delete();
    pat_q.delete();
    nReset = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    // Start held high during reset must not begin a run.
    Start = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    chk("reset_wins_busy", 32'(Busy), 0);
    Start = 1'b0;
    @(negedge Clock) nReset = 1'b1;
    do_run(0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
